// File: rtl/mips_pkg.sv
// Shared decode definitions for the MIPS-style decode stage.
// Holds the primary opcode constants, the ALU operation encodings, the
// control bundle layout carried through ID/EX, and the opcode decode table.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  // Field order matches {reg_dst, alu_op, alu_src, branch, mem_read,
  // mem_write, mem_to_reg, reg_write}, MSB first.
  typedef struct packed {
    logic    reg_dst;
    alu_op_e alu_op;
    logic    alu_src;
    logic    branch;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI);
  endfunction

  // Unknown opcodes decode to an all-zero bundle so they cannot write state.
  function automatic ctrl_t decode_op(input logic [5:0] op);
    case (op)
      OP_RTYPE: return '{reg_dst: 1'b1, alu_op: ALU_FUNCT, alu_src: 1'b0, branch: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1};
      OP_LW:    return '{reg_dst: 1'b0, alu_op: ALU_ADD, alu_src: 1'b1, branch: 1'b0,
                         mem_read: 1'b1, mem_write: 1'b0, mem_to_reg: 1'b1, reg_write: 1'b1};
      OP_SW:    return '{reg_dst: 1'b0, alu_op: ALU_ADD, alu_src: 1'b1, branch: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b1, mem_to_reg: 1'b0, reg_write: 1'b0};
      OP_BEQ:   return '{reg_dst: 1'b0, alu_op: ALU_SUB, alu_src: 1'b0, branch: 1'b1,
                         mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0};
      OP_ADDI:  return '{reg_dst: 1'b0, alu_op: ALU_ADD, alu_src: 1'b1, branch: 1'b0,
                         mem_read: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b1};
      default:  return CTRL_NOP;
    endcase
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with write-through read bypass.
// Ports:
//   clk, reset            - clock, synchronous active-high reset (clears all registers)
//   i_we, i_waddr, i_wdata - writeback port; writes to register 0 are ignored
//   i_raddr_a, i_raddr_b  - combinational read addresses
//   o_rdata_a, o_rdata_b  - read data; register 0 reads zero, a same-cycle
//                           write to the read address is forwarded
module regfile_bypass #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b
);

  logic [XLEN-1:0] r_mem [NREG];

  // A writeback arriving in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // A non-zero read address matching the write address implies a non-zero write.
  assign o_rdata_a = (i_raddr_a == '0)                  ? '0      :
                     (i_we && (i_waddr == i_raddr_a))   ? i_wdata : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0)                  ? '0      :
                     (i_we && (i_waddr == i_raddr_b))   ? i_wdata : r_mem[i_raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage with ID/EX pipeline register.
// Decodes instr_i into control flags, reads operands from the bypassed
// register file, sign-extends the immediate, detects load-use hazards and
// registers everything into ID/EX one cycle later.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   instr_i, pc_i, in_valid_i        - fetched instruction, its PC, valid
//   wb_we_i, wb_addr_i, wb_data_i    - register file writeback
//   flush_i                          - squash the instruction in decode
//   stall_o                          - combinational load-use stall to fetch
//   out_valid_o, ctrl flags, illegal_o - registered ID/EX control
//   rdata_a_o, rdata_b_o, imm_o, rs_o, rt_o, rd_o, pc_o - registered datapath
module decode_stage
  import mips_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int PCW  = 10,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr_i,
  input  logic            in_valid_i,
  input  logic [PCW-1:0]  pc_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            out_valid_o,
  output logic            reg_dst_o,
  output logic [1:0]      alu_op_o,
  output logic            alu_src_o,
  output logic            branch_o,
  output logic            mem_read_o,
  output logic            mem_write_o,
  output logic            mem_to_reg_o,
  output logic            reg_write_o,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o,
  output logic [XLEN-1:0] imm_o,
  output logic [AW-1:0]   rs_o,
  output logic [AW-1:0]   rt_o,
  output logic [AW-1:0]   rd_o,
  output logic [PCW-1:0]  pc_o,
  output logic            illegal_o
);

  logic [5:0]        w_op;
  logic [AW-1:0]     w_rs;
  logic [AW-1:0]     w_rt;
  logic [AW-1:0]     w_rd;
  logic signed [15:0] w_imm16;
  logic [XLEN-1:0]   w_imm;
  ctrl_t             w_ctrl;
  logic              w_legal;
  logic [XLEN-1:0]   w_rdata_a;
  logic [XLEN-1:0]   w_rdata_b;
  logic              w_stall;
  logic              w_bubble;

  ctrl_t             r_ctrl_p1;
  logic              r_vld_p1;
  logic              r_illegal_p1;
  logic [XLEN-1:0]   r_rdata_a_p1;
  logic [XLEN-1:0]   r_rdata_b_p1;
  logic [XLEN-1:0]   r_imm_p1;
  logic [AW-1:0]     r_rs_p1;
  logic [AW-1:0]     r_rt_p1;
  logic [AW-1:0]     r_rd_p1;
  logic [PCW-1:0]    r_pc_p1;

  // ---- ID stage: field extraction, decode, operand read ----
  assign w_op    = instr_i[31:26];
  assign w_rs    = AW'(instr_i[25:21]);
  assign w_rt    = AW'(instr_i[20:16]);
  assign w_rd    = AW'(instr_i[15:11]);
  assign w_imm16 = instr_i[15:0];
  assign w_imm   = XLEN'(w_imm16);
  assign w_ctrl  = decode_op(w_op);
  assign w_legal = is_legal_op(w_op);

  regfile_bypass #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (wb_we_i),
    .i_waddr   (wb_addr_i),
    .i_wdata   (wb_data_i),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b)
  );

  // A load in ID/EX whose destination is a source of the instruction in
  // decode cannot forward in time; hold fetch for one cycle. Masked by
  // reset so stale ID/EX contents never stall while resetting.
  assign w_stall  = ~reset & in_valid_i & r_vld_p1 & r_ctrl_p1.mem_read &
                    (r_rt_p1 != '0) & ((r_rt_p1 == w_rs) | (r_rt_p1 == w_rt));
  assign w_bubble = flush_i | w_stall;
  assign stall_o  = w_stall;

  // ---- ID/EX boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1     <= 1'b0;
      r_ctrl_p1    <= CTRL_NOP;
      r_illegal_p1 <= 1'b0;
    end else if (w_bubble) begin
      r_vld_p1     <= 1'b0;
      r_ctrl_p1    <= CTRL_NOP;
      r_illegal_p1 <= 1'b0;
    end else begin
      r_vld_p1     <= in_valid_i;
      r_ctrl_p1    <= in_valid_i ? w_ctrl : CTRL_NOP;
      r_illegal_p1 <= in_valid_i & ~w_legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a_p1 <= '0;
      r_rdata_b_p1 <= '0;
      r_imm_p1     <= '0;
      r_rs_p1      <= '0;
      r_rt_p1      <= '0;
      r_rd_p1      <= '0;
      r_pc_p1      <= '0;
    end else if (!w_bubble) begin
      r_rdata_a_p1 <= w_rdata_a;
      r_rdata_b_p1 <= w_rdata_b;
      r_imm_p1     <= w_imm;
      r_rs_p1      <= w_rs;
      r_rt_p1      <= w_rt;
      r_rd_p1      <= w_rd;
      r_pc_p1      <= pc_i;
    end
  end

  assign out_valid_o  = r_vld_p1;
  assign reg_dst_o    = r_ctrl_p1.reg_dst;
  assign alu_op_o     = r_ctrl_p1.alu_op;
  assign alu_src_o    = r_ctrl_p1.alu_src;
  assign branch_o     = r_ctrl_p1.branch;
  assign mem_read_o   = r_ctrl_p1.mem_read;
  assign mem_write_o  = r_ctrl_p1.mem_write;
  assign mem_to_reg_o = r_ctrl_p1.mem_to_reg;
  assign reg_write_o  = r_ctrl_p1.reg_write;
  assign illegal_o    = r_illegal_p1;
  assign rdata_a_o    = r_rdata_a_p1;
  assign rdata_b_o    = r_rdata_b_p1;
  assign imm_o        = r_imm_p1;
  assign rs_o         = r_rs_p1;
  assign rt_o         = r_rt_p1;
  assign rd_o         = r_rd_p1;
  assign pc_o         = r_pc_p1;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, register count (power of two); AW = log2(NREG).
REQ-003 Parameter PCW, default 10, program-counter width.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 instr_i  in  32  fetched instruction; in_valid_i  in  1  instr_i/pc_i valid.
REQ-007 pc_i  in  PCW  PC of instr_i.
REQ-008 wb_we_i  in  1, wb_addr_i  in  AW, wb_data_i  in  XLEN  writeback port.
REQ-009 flush_i  in  1  branch taken; squash decode.
REQ-010 stall_o  out  1  hold fetch and PC this cycle (load-use hazard).
REQ-011 out_valid_o  out  1  ID/EX register holds a real instruction.
REQ-012 ctrl outputs (registered): reg_dst_o, alu_op_o[1:0], alu_src_o, branch_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o.
REQ-013 rdata_a_o, rdata_b_o, imm_o  out  XLEN  registered operands and sign-extended immediate.
REQ-014 rs_o, rt_o, rd_o  out  AW; pc_o  out  PCW; illegal_o  out  1  registered.

Function
REQ-015 Register file: NREG x XLEN, written on rising edge when wb_we_i and wb_addr_i != 0; register 0 reads zero always.
REQ-016 Read bypass: a read address equal to a same-cycle non-zero wb_addr_i with wb_we_i returns wb_data_i (write-through).
REQ-017 Source fields: rs = instr_i[25:21], rt = instr_i[20:16], rd = instr_i[15:11], truncated/zero-extended to AW.
REQ-018 imm = instr_i[15:0] sign-extended to XLEN.
REQ-019 Opcode decode (instr_i[31:26]), flags as {reg_dst,alu_op,alu_src,branch,mem_read,mem_write,mem_to_reg,reg_write}: 0x00 R-type {1,10,0,0,0,0,0,1}; 0x23 lw {0,00,1,0,1,0,1,1}; 0x2B sw {0,00,1,0,0,1,0,0}; 0x04 beq {0,01,0,1,0,0,0,0}; 0x08 addi {0,00,1,0,0,0,0,1}.
REQ-020 Any other opcode with in_valid_i: all controls zero, illegal_o = 1, out_valid_o = 1.
REQ-021 Hazard: stall_o = in_valid_i & mem_read_o & out_valid_o & (rt_o != 0) & (rt_o == rs or rt_o == rt of instr_i), combinational.
REQ-022 Update priority each edge: reset, then flush_i, then stall_o, then load.
REQ-023 flush_i: out_valid_o, all controls, illegal_o cleared (bubble); datapath fields don't-care.
REQ-024 stall_o: bubble inserted (as REQ-023); instr_i is re-presented by fetch next cycle; register file writes still occur.
REQ-025 Load: all ID/EX outputs take decoded values; out_valid_o = in_valid_i; in_valid_i = 0 yields a bubble.
REQ-026 Latency: one cycle from instr_i to ID/EX outputs; stall lasts exactly one cycle per load-use pair.
REQ-027 flush_i with stall_o in same cycle: flush wins; stall_o still asserted combinationally.

Reset
REQ-028 On reset all ID/EX outputs and out_valid_o become 0 at the next edge.
REQ-029 Register file contents cleared to 0 on reset; a writeback in the reset cycle is dropped.
REQ-030 stall_o is 0 during and in the first cycle after reset (mem_read_o = 0).

Structure
REQ-031 Opcode constants, alu_op encodings and the ctrl bundle layout live in shared package mips_pkg.
REQ-032 Register file is sub-module regfile_bypass (params XLEN, NREG); decode table and hazard logic stay in decode_stage.

Verification
REQ-033 Write r5=0x1234 via wb; next cycle decode add r3,r5,r0 -> rdata_a_o=0x1234, reg_write_o=1, alu_op_o=10.
REQ-034 Same-cycle wb r7=0xCAFE and decode reading r7 -> rdata_a_o=0xCAFE one cycle later.
REQ-035 lw r2 then add r4,r2,r1 -> stall_o=1 one cycle, bubble (out_valid_o=0) emitted, add issues next cycle.
REQ-036 lw r0 followed by use of r0 -> no stall; wb to r0 -> r0 still reads 0.
REQ-037 flush_i with valid beq and concurrent hazard -> out_valid_o=0, branch_o=0 next cycle.
REQ-038 Opcode 0x3F -> illegal_o=1, controls zero; reset mid-stream -> all outputs 0 next edge.
